i2s_audio_tx: RTL and testbench
===============================

Name: i2s_audio_tx

Overview:
- Final audio output stage. Drains the left and right post-volume sample FIFOs (the left_volume/right_volume streams) through their read-side interface (dout, empty, rd_en).
- Saturates each 32-bit sample to SAMPLE_BITS and serializes the stereo pair onto a standard I2S link to the DAC.
- Sole consumer of both FIFOs; pops left and right strictly as a pair.

Parameters:
- DATA_WIDTH, 32: FIFO word width; samples are signed two's complement.
- SAMPLE_BITS, 16: I2S word length per channel. Range 8..DATA_WIDTH.
- BCLK_DIV, 8: clock cycles per bclk half-period. Must be at least 2.
- UNDERRUN_W, 16: width of the underrun counter.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-low.
- enable, in, 1: run request.
- left_dout, in, DATA_WIDTH: left FIFO head word (first-word-fall-through), valid while left_empty=0.
- left_empty, in, 1: left FIFO empty.
- left_rd_en, out, 1: left FIFO pop.
- right_dout, in, DATA_WIDTH: right FIFO head word.
- right_empty, in, 1: right FIFO empty.
- right_rd_en, out, 1: right FIFO pop.
- bclk, out, 1: I2S bit clock.
- lrclk, out, 1: I2S word select; 0 = left.
- sdata, out, 1: I2S serial data, MSB first.
- running, out, 1: frame generation active.
- underrun_count, out, UNDERRUN_W: saturating count of frames sent as silence.

Behaviour:
- Reset: asynchronous, active-low. Sets left_rd_en=right_rd_en=0, bclk=0, lrclk=1, sdata=0, running=0, underrun_count=0. Clears the holding register, shift register and counters. Reset mid-frame discards the held pair and the partial frame. FIFO contents are untouched.
- Fetch:
  - 1-entry holding register {hold_l, hold_r, hold_valid}.
  - When hold_valid=0 and left_empty=0 and right_empty=0, assert left_rd_en and right_rd_en together for exactly one cycle. In that same cycle latch both saturated dout values and set hold_valid=1.
  - Never pop one side alone. If only one FIFO is non-empty, wait with no rd_en.
  - Fetch operates in every state while enable=1. No fetch when enable=0.
- Saturation (combinational on dout):
  - value > 2^(SB-1)-1 gives 0x7FFF (SB=16).
  - value < -2^(SB-1) gives 0x8000.
  - Otherwise take the low SB bits.
- States:
  - IDLE: bclk=0, lrclk=1, sdata=0, running=0. Go to RUN when enable=1 and hold_valid=1. The divider starts at 0 on entry.
  - RUN: running=1. The divider counts 0..BCLK_DIV-1. On each wrap bclk toggles, so the slot period is 2*BCLK_DIV cycles.
  - Slot counter s counts 0..2*SB-1, advancing on each falling bclk. The first slot 0 begins on the first cycle of RUN with bclk=0.
  - Default frame period is 512 cycles.
- Frame load, on entry to slot 0:
  - If hold_valid=1: frame_word={hold_l, hold_r}, then clear hold_valid. A fetch may refill it in the same cycle.
  - Else: frame_word=0 and underrun_count increments, saturating at all-ones.
- I2S timing:
  - All outputs change only coincident with bclk falling.
  - lrclk=0 for slots 0..SB-1 and 1 for slots SB..2SB-1.
  - sdata lags by one slot, per standard I2S: slot s carries frame bit (2SB-1-(s-1)).
  - The left MSB appears in slot 1. The right LSB appears in slot 0 of the next frame.
  - The first frame after IDLE has sdata=0 in slot 0.
- Stop:
  - enable=0 during RUN completes the current frame, including the trailing right LSB slot, then returns to IDLE.
  - If hold_valid=1 at that point, the pair is retained.
- Simultaneous events: a pop in the same cycle as a frame load is legal. The load uses the old hold value and the pop writes the new one.

Test Plan:
- Single pair, L=0x00001234, R=0xFFFFFF00:
  - Exactly one paired pop.
  - lrclk low for 16 slots, then high for 16 slots.
  - sdata slots 1..16 = 0x1234 MSB first; slots 17..31 plus the next slot 0 = 0xFF00.
  - Then underrun_count becomes 1 on the next frame, with all-zero data.
- Saturation, L=0x00012345, R=0xFFFE0000: serialized words are 0x7FFF and 0x8000. L=0xFFFF8000 passes as 0x8000.
- Unbalanced, left non-empty for 50 cycles with right empty: no rd_en and running=0. When right_empty falls, both rd_en assert in the same single cycle.
- Stream of 100 pairs, FIFOs kept non-empty:
  - Exactly 100 pops.
  - Frame period 512 cycles.
  - underrun_count=0.
  - Received words match the expected file.
- Starvation, 3 pairs then FIFOs empty for 4 frames: underrun_count=4, bclk keeps toggling, silent frames. Refill resumes data on the next frame boundary.
- Reset at slot 10 of frame 2, and enable=0 at slot 5: reset gives immediate reset values. enable=0 gives completion through slot 0 of the next frame, then IDLE, lrclk=1.

Source files
------------

// File: rtl/i2s_audio_tx.sv
// Stereo I2S transmitter: pops paired left/right samples from two FWFT FIFOs,
// saturates them to SAMPLE_BITS and shifts them out MSB first with one-slot lag.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | link quiet (bclk=0, lrclk=1), waiting for enable and a held pair
// RUN     | frames being generated, next frame loaded at each slot-0 entry
// TAIL    | stop requested: emit the trailing right LSB slot, then IDLE
module i2s_audio_tx #(
    parameter int DATA_WIDTH  = 32,
    parameter int SAMPLE_BITS = 16,
    parameter int BCLK_DIV    = 8,
    parameter int UNDERRUN_W  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] left_dout,
    input  logic                  left_empty,
    output logic                  left_rd_en,
    input  logic [DATA_WIDTH-1:0] right_dout,
    input  logic                  right_empty,
    output logic                  right_rd_en,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  running,
    output logic [UNDERRUN_W-1:0] underrun_count
);

    localparam int FRAME_BITS = 2 * SAMPLE_BITS;
    localparam int DIV_W      = $clog2(BCLK_DIV);
    localparam int SLOT_W     = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0]  DIV_LAST       = DIV_W'(BCLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST      = SLOT_W'(FRAME_BITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LEFT_LAST = SLOT_W'(SAMPLE_BITS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;

    logic [1:0]             state;
    logic [DIV_W-1:0]       div_cnt;
    logic [SLOT_W-1:0]      slot_cnt;
    logic [FRAME_BITS-1:0]  frame_sr;
    logic [SAMPLE_BITS-1:0] hold_l;
    logic [SAMPLE_BITS-1:0] hold_r;
    logic                   hold_valid;
    logic                   pop_q;
    logic                   bclk_q;
    logic                   lrclk_q;
    logic                   sdata_q;
    logic [UNDERRUN_W-1:0]  underrun_q;

    logic [SAMPLE_BITS-1:0] left_sat;
    logic [SAMPLE_BITS-1:0] right_sat;
    logic                   div_wrap;
    logic                   bclk_fall;
    logic                   start_run;
    logic                   frame_wrap;
    logic                   take_hold;
    logic                   starve;
    logic                   pop_fire;
    logic                   pop_req;

    // Clamp a signed word to the signed SAMPLE_BITS range.
    function automatic logic [SAMPLE_BITS-1:0] sat_sample(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-SAMPLE_BITS:0] top_bits;
        top_bits = v[DATA_WIDTH-1:SAMPLE_BITS-1];
        if ((&top_bits) || !(|top_bits))
            sat_sample = v[SAMPLE_BITS-1:0];
        else if (v[DATA_WIDTH-1])
            sat_sample = {1'b1, {(SAMPLE_BITS-1){1'b0}}};
        else
            sat_sample = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
    endfunction

    assign left_sat  = sat_sample(left_dout);
    assign right_sat = sat_sample(right_dout);

    assign div_wrap   = (div_cnt == DIV_LAST);
    assign bclk_fall  = (state != ST_IDLE) && div_wrap && bclk_q;
    assign start_run  = (state == ST_IDLE) && enable && hold_valid;
    assign frame_wrap = (state == ST_RUN) && bclk_fall && (slot_cnt == SLOT_LAST) && enable;
    assign take_hold  = start_run || (frame_wrap && hold_valid);
    assign starve     = frame_wrap && !hold_valid;

    // The pop is decided one cycle ahead; enable gates the actual strobe so
    // dropping enable cancels a pending pop.
    assign pop_fire = pop_q && enable;
    assign pop_req  = enable && !left_empty && !right_empty && !pop_q
                      && (!hold_valid || take_hold);

    assign left_rd_en     = pop_fire;
    assign right_rd_en    = pop_fire;
    assign bclk           = bclk_q;
    assign lrclk          = lrclk_q;
    assign sdata          = sdata_q;
    assign running        = (state != ST_IDLE);
    assign underrun_count = underrun_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pop_q      <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
            hold_valid <= 1'b0;
            underrun_q <= '0;
        end else begin
            pop_q <= pop_req;
            if (pop_fire) begin
                hold_l     <= left_sat;
                hold_r     <= right_sat;
                hold_valid <= 1'b1;
            end else if (take_hold) begin
                hold_valid <= 1'b0;
            end
            if (starve && !(&underrun_q))
                underrun_q <= underrun_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            slot_cnt <= '0;
            frame_sr <= '0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b1;
            sdata_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    div_cnt  <= '0;
                    slot_cnt <= '0;
                    bclk_q   <= 1'b0;
                    lrclk_q  <= 1'b1;
                    sdata_q  <= 1'b0;
                    if (start_run) begin
                        state    <= ST_RUN;
                        lrclk_q  <= 1'b0;
                        frame_sr <= {hold_l, hold_r};
                    end
                end
                ST_RUN: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        bclk_q  <= ~bclk_q;
                        // Falling bclk: advance the slot, emit the previous slot's bit.
                        if (bclk_q) begin
                            sdata_q <= frame_sr[FRAME_BITS-1];
                            if (slot_cnt == SLOT_LAST) begin
                                slot_cnt <= '0;
                                lrclk_q  <= 1'b0;
                                if (enable)
                                    frame_sr <= hold_valid ? {hold_l, hold_r} : '0;
                                else
                                    state <= ST_TAIL;
                            end else begin
                                slot_cnt <= slot_cnt + 1'b1;
                                lrclk_q  <= (slot_cnt >= SLOT_LEFT_LAST);
                                frame_sr <= {frame_sr[FRAME_BITS-2:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                ST_TAIL: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        bclk_q  <= ~bclk_q;
                        if (bclk_q) begin
                            state    <= ST_IDLE;
                            slot_cnt <= '0;
                            lrclk_q  <= 1'b1;
                            sdata_q  <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: FIFO models, an I2S receiver and
// hand-computed expected frames, counters and timings.
module tb_i2s_audio_tx;

    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] left_dout = '0;
    logic [DW-1:0] right_dout = '0;
    logic          left_empty = 1'b1;
    logic          right_empty = 1'b1;
    logic          left_rd_en, right_rd_en, bclk, lrclk, sdata, running;
    logic [15:0]   underrun_count;

    i2s_audio_tx #(.DATA_WIDTH(32), .SAMPLE_BITS(16), .BCLK_DIV(8), .UNDERRUN_W(16)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .left_dout(left_dout), .left_empty(left_empty), .left_rd_en(left_rd_en),
        .right_dout(right_dout), .right_empty(right_empty), .right_rd_en(right_rd_en),
        .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .running(running),
        .underrun_count(underrun_count)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] lq[$];
    logic [DW-1:0] rq[$];
    int cyc = 0;
    int underflow = 0;

    always @(posedge clock) begin
        cyc++;
        if (left_rd_en) begin
            if (lq.size() > 0) lq.delete(0); else underflow++;
        end
        if (right_rd_en) begin
            if (rq.size() > 0) rq.delete(0); else underflow++;
        end
    end

    // FIFO heads become visible half a cycle after a push or pop.
    always @(negedge clock) begin
        left_empty  = (lq.size() == 0);
        right_empty = (rq.size() == 0);
        left_dout   = left_empty  ? '0 : lq[0];
        right_dout  = right_empty ? '0 : rq[0];
    end

    logic [15:0] cap_l[$];
    logic [15:0] cap_r[$];
    int cap_lo[$];
    int cap_hi[$];
    logic [31:0] rx = '0;
    logic bclk_d = 1'b0, lrclk_d = 1'b1, rx_lr_d = 1'b0;
    int lo_cnt = 0, hi_cnt = 0, tb_slot = 0, frame_idx = 0, frame_t0 = 0;
    int pops = 0, pair_err = 0, bclk_rises = 0;
    bit track_period = 0;
    int last_fall = -1, pmin = 1000000, pmax = 0;

    always @(negedge clock) begin
        if (!reset) begin
            bclk_d = 1'b0; lrclk_d = 1'b1; rx_lr_d = 1'b0;
            tb_slot = 0; frame_idx = 0; lo_cnt = 0; hi_cnt = 0;
        end else begin
            if (left_rd_en !== right_rd_en) pair_err++;
            if (left_rd_en) pops++;
            if (lrclk_d && !lrclk) begin
                tb_slot = 0;
                frame_idx++;
                frame_t0 = cyc;
                if (track_period) begin
                    if (last_fall >= 0) begin
                        if (cyc - last_fall < pmin) pmin = cyc - last_fall;
                        if (cyc - last_fall > pmax) pmax = cyc - last_fall;
                    end
                    last_fall = cyc;
                end
            end else if (bclk_d && !bclk) begin
                tb_slot++;
            end
            if (!bclk_d && bclk) begin
                bclk_rises++;
                rx = {rx[30:0], sdata};
                if (!lrclk && rx_lr_d) begin
                    cap_l.push_back(rx[31:16]);
                    cap_r.push_back(rx[15:0]);
                    cap_lo.push_back(lo_cnt);
                    cap_hi.push_back(hi_cnt);
                    lo_cnt = 1; hi_cnt = 0;
                end else if (lrclk) hi_cnt++;
                else lo_cnt++;
                rx_lr_d = lrclk;
            end
            if (!running) begin lo_cnt = 0; hi_cnt = 0; end
            bclk_d = bclk;
            lrclk_d = lrclk;
        end
    end

    int n_vec = 0, n_bad = 0;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
        lq.push_back(l);
        rq.push_back(r);
    endtask

    task automatic wait_caps(input int n, input int budget, input string tag);
        for (int k = 0; k < budget && cap_l.size() < n; k++) @(negedge clock);
        chk_val(tag, (cap_l.size() >= n), 1);
    endtask

    task automatic wait_running(input logic val, input int budget, input string tag);
        for (int k = 0; k < budget && running !== val; k++) @(negedge clock);
        chk_val(tag, running, val);
    endtask

    // Start from IDLE, run n frames and stop; the first slot must be silent.
    task automatic run_frames(input int n, input string tag);
        int b;
        b = cap_l.size();
        enable = 1'b1;
        wait_running(1'b1, 100, {tag, "_start"});
        chk_val({tag, "_slot0_sdata"}, {lrclk, sdata}, 2'b00);
        if (n > 1) wait_caps(b + n - 1, n * 512 + 200, {tag, "_frames"});
        enable = 1'b0;
        wait_running(1'b0, 700, {tag, "_stop"});
    endtask

    task automatic check_frame(input int idx, input logic [15:0] el, input logic [15:0] er,
                               input string tag);
        logic [63:0] obs_l, obs_r;
        obs_l = 'x;
        obs_r = 'x;
        if (idx < cap_l.size()) begin
            obs_l = 64'(cap_l[idx]);
            obs_r = 64'(cap_r[idx]);
        end
        chk_val({tag, "_L"}, obs_l, 64'(el));
        chk_val({tag, "_R"}, obs_r, 64'(er));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, p0, bad, fb, t0, r0;

        repeat (3) @(negedge clock);
        chk_val("rst_rd_en", {left_rd_en, right_rd_en}, 2'b00);
        chk_val("rst_bclk", bclk, 1'b0);
        chk_val("rst_lrclk", lrclk, 1'b1);
        chk_val("rst_sdata", sdata, 1'b0);
        chk_val("rst_running", running, 1'b0);
        chk_val("rst_underrun", underrun_count, 16'd0);
        reset = 1'b1;
        @(negedge clock);

        // Single pair followed by one silent frame.
        push_pair(32'h0000_1234, 32'hFFFF_FF00);
        b = cap_l.size(); p0 = pops;
        run_frames(2, "single");
        chk_val("single_pops", pops - p0, 1);
        check_frame(b, 16'h1234, 16'hFF00, "single_f1");
        chk_val("single_lrclk_lo", (b < cap_lo.size()) ? cap_lo[b] : -1, 16);
        chk_val("single_lrclk_hi", (b < cap_hi.size()) ? cap_hi[b] : -1, 16);
        check_frame(b + 1, 16'h0000, 16'h0000, "single_f2");
        chk_val("single_underrun", underrun_count, 16'd1);
        chk_val("single_idle", {lrclk, bclk, sdata}, 3'b100);

        // Saturation.
        push_pair(32'h0001_2345, 32'hFFFE_0000);
        push_pair(32'hFFFF_8000, 32'h0000_0005);
        b = cap_l.size();
        run_frames(2, "sat");
        check_frame(b, 16'h7FFF, 16'h8000, "sat_f1");
        check_frame(b + 1, 16'h8000, 16'h0005, "sat_f2");
        chk_val("sat_underrun", underrun_count, 16'd1);

        // Left non-empty alone must never pop.
        lq.push_back(32'h0000_0042);
        enable = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clock);
            if (left_rd_en || right_rd_en || running) bad++;
        end
        chk_val("unbal_wait", bad, 0);
        rq.push_back(32'hFFFF_FFFF);
        p0 = pops;
        for (int k = 0; k < 10 && !left_rd_en; k++) @(negedge clock);
        chk_val("unbal_pop", {left_rd_en, right_rd_en}, 2'b11);
        @(negedge clock);
        chk_val("unbal_pop_once", {left_rd_en, right_rd_en}, 2'b00);
        chk_val("unbal_pops", pops - p0, 1);
        enable = 1'b0;
        b = cap_l.size();
        run_frames(1, "unbal");
        check_frame(b, 16'h0042, 16'hFFFF, "unbal_f1");

        // Long stream after a fresh reset.
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        for (int i = 1; i <= 100; i++) push_pair(32'(i * 32'h123), 32'(-(i * 137)));
        b = cap_l.size(); p0 = pops;
        track_period = 1;
        run_frames(100, "stream");
        track_period = 0;
        chk_val("stream_pops", pops - p0, 100);
        chk_val("stream_underrun", underrun_count, 16'd0);
        chk_val("stream_period_min", pmin, 512);
        chk_val("stream_period_max", pmax, 512);
        chk_val("stream_count", cap_l.size() - b, 100);
        bad = 0;
        for (int i = 1; i <= 100; i++) begin
            if (b + i - 1 >= cap_l.size()) bad++;
            else if (cap_l[b + i - 1] !== 16'(i * 32'h123) || cap_r[b + i - 1] !== 16'(-(i * 137))) bad++;
        end
        chk_val("stream_data", bad, 0);
        check_frame(b, 16'h0123, 16'hFF77, "stream_first");
        check_frame(b + 99, 16'h71AC, 16'hCA7C, "stream_last");

        // Starvation: 3 pairs, 4 silent frames, then refill.
        push_pair(32'h1111, 32'h2222);
        push_pair(32'h3333, 32'h4444);
        push_pair(32'h5555, 32'h6666);
        b = cap_l.size();
        enable = 1'b1;
        for (int k = 0; k < 8 * 512 && underrun_count != 16'd4; k++) @(negedge clock);
        chk_val("starve_underrun4", underrun_count, 16'd4);
        r0 = bclk_rises;
        push_pair(32'h0ABC, 32'h0DEF);
        push_pair(32'h7001, 32'h7002);
        repeat (256) @(negedge clock);
        chk_val("starve_bclk", bclk_rises - r0, 16);
        wait_caps(b + 8, 3 * 512, "starve_frames");
        enable = 1'b0;
        wait_running(1'b0, 700, "starve_stop");
        chk_val("starve_underrun", underrun_count, 16'd4);
        check_frame(b, 16'h1111, 16'h2222, "starve_f1");
        check_frame(b + 2, 16'h5555, 16'h6666, "starve_f3");
        bad = 0;
        for (int i = 3; i <= 6; i++)
            if (i >= cap_l.size() - b || cap_l[b + i] !== 16'h0 || cap_r[b + i] !== 16'h0) bad++;
        chk_val("starve_silent", bad, 0);
        check_frame(b + 7, 16'h0ABC, 16'h0DEF, "starve_refill1");
        check_frame(b + 8, 16'h7001, 16'h7002, "starve_refill2");

        // Reset mid-frame, then stop mid-frame.
        push_pair(32'h0101, 32'h0202);
        push_pair(32'h0303, 32'h0404);
        push_pair(32'h0505, 32'h0606);
        push_pair(32'h0707, 32'h0003);
        push_pair(32'h0909, 32'h0A0A);
        fb = frame_idx;
        enable = 1'b1;
        for (int k = 0; k < 3 * 512 && !(frame_idx == fb + 2 && tb_slot == 10); k++) @(negedge clock);
        chk_val("rstmid_reach", (frame_idx == fb + 2 && tb_slot == 10), 1);
        #2 reset = 1'b0;
        #1;
        chk_val("rstmid_rd_en", {left_rd_en, right_rd_en}, 2'b00);
        chk_val("rstmid_lines", {bclk, lrclk, sdata}, 3'b010);
        chk_val("rstmid_running", running, 1'b0);
        chk_val("rstmid_underrun", underrun_count, 16'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        chk_val("rstmid_fifo_kept", lq.size(), 2);
        b = cap_l.size();
        fb = frame_idx;
        wait_running(1'b1, 100, "rstmid_restart");
        for (int k = 0; k < 600 && !(frame_idx == fb + 1 && tb_slot == 5); k++) @(negedge clock);
        chk_val("stop_reach", (frame_idx == fb + 1 && tb_slot == 5), 1);
        t0 = frame_t0;
        enable = 1'b0;
        wait_running(1'b0, 700, "stop_idle");
        chk_val("stop_len", cyc - t0, 528);
        chk_val("stop_lrclk", lrclk, 1'b1);
        check_frame(b, 16'h0707, 16'h0003, "stop_f1");
        chk_val("stop_fifo_drained", lq.size(), 0);
        run_frames(1, "retain");
        check_frame(b + 1, 16'h0909, 16'h0A0A, "retain_f1");
        chk_val("retain_underrun", underrun_count, 16'd0);

        chk_val("rd_en_paired", pair_err, 0);
        chk_val("fifo_underflow", underflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
